// File: rtl/bus_rd_arbiter.sv
// Round-robin arbiter sharing one AR/R read channel among NUM_REQ readers, one burst in flight.
// Optional address/data watchdog is built only when RD_TIMEOUT_EN is defined.
module bus_rd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 28,
    parameter int ID_W        = 4,
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        ReqArb_arvalid,
    input  logic [NUM_REQ*ID_W-1:0]   ReqArb_aruserid,
    input  logic [NUM_REQ*LEN_W-1:0]  ReqArb_arlen,
    input  logic [NUM_REQ-1:0]        ReqArb_aruserap,
    input  logic [NUM_REQ*ADDR_W-1:0] ReqArb_araddr,
    output logic [NUM_REQ-1:0]        ArbReq_arready,
    output logic [NUM_REQ-1:0]        ArbReq_rvalid,
    output logic                      ArbReq_rlast,
    output logic [31:0]               ArbReq_rdata,
    output logic                      ArbBus_arvalid,
    output logic [ID_W-1:0]           ArbBus_aruserid,
    output logic [LEN_W-1:0]          ArbBus_arlen,
    output logic                      ArbBus_aruserap,
    output logic [ADDR_W-1:0]         ArbBus_araddr,
    input  logic                      BusArb_arready,
    input  logic                      BusArb_rvalid,
    input  logic                      BusArb_rlast,
    input  logic [ID_W-1:0]           BusArb_rid,
    input  logic [31:0]               BusArb_rdata,
    output logic                      ArbSt_busy,
    output logic [2:0]                ArbSt_grant,
    output logic                      ArbErr_len,
    output logic                      ArbErr_timeout,
    input  logic                      ArbErr_clr
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [GW-1:0]     grant, last_grant, pick;
    logic              pick_vld;
    logic [LEN_W:0]    beat_cnt;
    logic              addr_done, beat_hit, last_hit, len_bad, to_hit, to_fire;

    logic [ID_W-1:0]   req_id   [NUM_REQ];
    logic [LEN_W-1:0]  req_len  [NUM_REQ];
    logic [ADDR_W-1:0] req_addr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_id[i]   = ReqArb_aruserid[i*ID_W +: ID_W];
        assign req_len[i]  = ReqArb_arlen[i*LEN_W +: LEN_W];
        assign req_addr[i] = ReqArb_araddr[i*ADDR_W +: ADDR_W];
    end

    // First requester after last_grant, wrapping around.
    always_comb begin : rr_pick
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!pick_vld && ReqArb_arvalid[GW'(idx)]) begin
                pick     = GW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign addr_done = (state == ADDR) && BusArb_arready;
    assign beat_hit  = (state == DATA) && BusArb_rvalid && (BusArb_rid == ArbBus_aruserid);
    assign last_hit  = beat_hit && BusArb_rlast;
    assign len_bad   = (beat_cnt + (LEN_W+1)'(1)) !=
                       ((LEN_W+1)'(ArbBus_arlen) + (LEN_W+1)'(1));
    // A handshake or final beat in the same cycle as expiry completes normally.
    assign to_fire   = to_hit && !addr_done && !last_hit;

`ifdef RD_TIMEOUT_EN
    logic [15:0] to_cnt;

    assign to_hit = (state != IDLE) && (to_cnt == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt         <= '0;
            ArbErr_timeout <= 1'b0;
        end else begin
            to_cnt <= (state == IDLE) ? 16'd0 : to_cnt + 16'd1;
            if (to_fire)
                ArbErr_timeout <= 1'b1;
            else if (ArbErr_clr)
                ArbErr_timeout <= 1'b0;
        end
    end
`else
    assign to_hit         = 1'b0;
    assign ArbErr_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = ADDR;
            ADDR: begin
                if (addr_done)    state_nxt = DATA;
                else if (to_fire) state_nxt = IDLE;
            end
            DATA:    if (last_hit || to_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ArbReq_arready = '0;
        ArbReq_rvalid  = '0;
        ArbReq_rlast   = 1'b0;
        if (addr_done) ArbReq_arready[grant] = 1'b1;
        if (beat_hit)  ArbReq_rvalid[grant]  = 1'b1;
        if (state == DATA) ArbReq_rlast = BusArb_rlast;
    end

    assign ArbReq_rdata = BusArb_rdata;
    assign ArbSt_busy   = (state != IDLE);
    assign ArbSt_grant  = 3'(grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant           <= '0;
            last_grant      <= GW'(NUM_REQ - 1);
            beat_cnt        <= '0;
            ArbBus_arvalid  <= 1'b0;
            ArbBus_aruserid <= '0;
            ArbBus_arlen    <= '0;
            ArbBus_aruserap <= 1'b0;
            ArbBus_araddr   <= '0;
        end else begin
            if (state == IDLE && pick_vld) begin
                grant           <= pick;
                ArbBus_arvalid  <= 1'b1;
                ArbBus_aruserid <= req_id[pick];
                ArbBus_arlen    <= req_len[pick];
                ArbBus_aruserap <= ReqArb_aruserap[pick];
                ArbBus_araddr   <= req_addr[pick];
                beat_cnt        <= '0;
            end
            if (addr_done || to_fire)
                ArbBus_arvalid <= 1'b0;
            if (beat_hit)
                beat_cnt <= beat_cnt + (LEN_W+1)'(1);
            if (last_hit || to_fire)
                last_grant <= grant;
        end
    end

    // Setting a flag takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ArbErr_len <= 1'b0;
        else if (last_hit && len_bad)
            ArbErr_len <= 1'b1;
        else if (ArbErr_clr)
            ArbErr_len <= 1'b0;
    end

endmodule

// File: tb/tb_bus_rd_arbiter.sv
// Self-checking bench for bus_rd_arbiter: vector table, directed corner sequences and
// randomized bursts against a transaction-level round-robin model.
module tb_bus_rd_arbiter;
    localparam int N  = 4;
    localparam int AW = 28;
    localparam int IW = 4;
    localparam int LW = 4;
`ifdef RD_TIMEOUT_EN
    localparam int TB_TO = 16;
`else
    localparam int TB_TO = 1024;
`endif

    logic            clk, rst_n;
    logic [N-1:0]    ReqArb_arvalid;
    logic [N*IW-1:0] ReqArb_aruserid;
    logic [N*LW-1:0] ReqArb_arlen;
    logic [N-1:0]    ReqArb_aruserap;
    logic [N*AW-1:0] ReqArb_araddr;
    logic [N-1:0]    ArbReq_arready, ArbReq_rvalid;
    logic            ArbReq_rlast;
    logic [31:0]     ArbReq_rdata;
    logic            ArbBus_arvalid;
    logic [IW-1:0]   ArbBus_aruserid;
    logic [LW-1:0]   ArbBus_arlen;
    logic            ArbBus_aruserap;
    logic [AW-1:0]   ArbBus_araddr;
    logic            BusArb_arready, BusArb_rvalid, BusArb_rlast;
    logic [IW-1:0]   BusArb_rid;
    logic [31:0]     BusArb_rdata;
    logic            ArbSt_busy;
    logic [2:0]      ArbSt_grant;
    logic            ArbErr_len, ArbErr_timeout, ArbErr_clr;

    logic [IW-1:0]   req_id   [N];
    logic [LW-1:0]   req_len  [N];
    logic            req_ap   [N];
    logic [AW-1:0]   req_addr [N];

    int checks   = 0;
    int failures = 0;

    bus_rd_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .ID_W(IW), .LEN_W(LW), .TIMEOUT_CYC(TB_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ReqArb_arvalid(ReqArb_arvalid), .ReqArb_aruserid(ReqArb_aruserid),
        .ReqArb_arlen(ReqArb_arlen), .ReqArb_aruserap(ReqArb_aruserap),
        .ReqArb_araddr(ReqArb_araddr),
        .ArbReq_arready(ArbReq_arready), .ArbReq_rvalid(ArbReq_rvalid),
        .ArbReq_rlast(ArbReq_rlast), .ArbReq_rdata(ArbReq_rdata),
        .ArbBus_arvalid(ArbBus_arvalid), .ArbBus_aruserid(ArbBus_aruserid),
        .ArbBus_arlen(ArbBus_arlen), .ArbBus_aruserap(ArbBus_aruserap),
        .ArbBus_araddr(ArbBus_araddr),
        .BusArb_arready(BusArb_arready), .BusArb_rvalid(BusArb_rvalid),
        .BusArb_rlast(BusArb_rlast), .BusArb_rid(BusArb_rid), .BusArb_rdata(BusArb_rdata),
        .ArbSt_busy(ArbSt_busy), .ArbSt_grant(ArbSt_grant),
        .ArbErr_len(ArbErr_len), .ArbErr_timeout(ArbErr_timeout), .ArbErr_clr(ArbErr_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ReqArb_aruserid[i*IW +: IW] = req_id[i];
            ReqArb_arlen[i*LW +: LW]    = req_len[i];
            ReqArb_aruserap[i]          = req_ap[i];
            ReqArb_araddr[i*AW +: AW]   = req_addr[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [IW-1:0] id, input logic [LW-1:0] len,
                           input logic [AW-1:0] addr, input logic ap);
        req_id[i]   = id;
        req_len[i]  = len;
        req_addr[i] = addr;
        req_ap[i]   = ap;
    endtask

    task automatic do_reset();
        ReqArb_arvalid = '0;
        BusArb_arready = 1'b0;
        BusArb_rvalid  = 1'b0;
        BusArb_rlast   = 1'b0;
        BusArb_rid     = '0;
        BusArb_rdata   = '0;
        ArbErr_clr     = 1'b0;
        rst_n          = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Reference arbitration: first pending requester after the previous winner.
    function automatic int rr_pick(input int last, input logic [N-1:0] pend);
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (last + k) % N;
            if (pend[idx]) return idx;
        end
        return 0;
    endfunction

    // Called at posedge+1 while the arbiter is idle and requests are already driven.
    task automatic run_burst(input int w, input int nbeats, input int ar_dly, input int nfor,
                             input bit drop, input bit clr_last);
        int            fleft;
        logic [31:0]   d;
        logic [IW-1:0] fid;
        fleft = nfor;
        chk("pre_grant_arvalid", 32'(ArbBus_arvalid), 0);
        tick();
        ArbErr_clr = 1'b0;
        if (drop) ReqArb_arvalid[w] = 1'b0;
        chk("bus_arvalid", 32'(ArbBus_arvalid), 1);
        chk("busy_addr", 32'(ArbSt_busy), 1);
        chk("grant", 32'(ArbSt_grant), w);
        chk("bus_id", 32'(ArbBus_aruserid), 32'(req_id[w]));
        chk("bus_len", 32'(ArbBus_arlen), 32'(req_len[w]));
        chk("bus_addr", 32'(ArbBus_araddr), 32'(req_addr[w]));
        chk("bus_ap", 32'(ArbBus_aruserap), 32'(req_ap[w]));
        for (int c = 0; c < ar_dly; c++) begin
            #1;
            chk("arready_wait", 32'(ArbReq_arready), 0);
            tick();
            chk("arvalid_hold", 32'(ArbBus_arvalid), 1);
            chk("addr_hold", 32'(ArbBus_araddr), 32'(req_addr[w]));
        end
        BusArb_arready = 1'b1;
        #1;
        chk("arready", 32'(ArbReq_arready), 32'(1) << w);
        tick();
        BusArb_arready    = 1'b0;
        ReqArb_arvalid[w] = 1'b0;
        chk("arvalid_drop", 32'(ArbBus_arvalid), 0);
        chk("busy_data_start", 32'(ArbSt_busy), 1);
        for (int b = 0; b < nbeats; b++) begin
            if (fleft > 0) begin
                fid           = req_id[w] ^ IW'($urandom_range(1, 15));
                BusArb_rvalid = 1'b1;
                BusArb_rid    = fid;
                BusArb_rdata  = $urandom;
                BusArb_rlast  = 1'($urandom_range(0, 1));
                #1;
                chk("foreign_rvalid", 32'(ArbReq_rvalid), 0);
                tick();
                fleft--;
            end
            d             = $urandom;
            BusArb_rvalid = 1'b1;
            BusArb_rid    = req_id[w];
            BusArb_rdata  = d;
            BusArb_rlast  = (b == nbeats - 1);
            if (clr_last && b == nbeats - 1) ArbErr_clr = 1'b1;
            #1;
            chk("rvalid", 32'(ArbReq_rvalid), 32'(1) << w);
            chk("rdata", ArbReq_rdata, d);
            chk("rlast", 32'(ArbReq_rlast), (b == nbeats - 1) ? 1 : 0);
            tick();
            BusArb_rvalid = 1'b0;
            BusArb_rlast  = 1'b0;
            ArbErr_clr    = 1'b0;
            if (b != nbeats - 1) chk("busy_mid", 32'(ArbSt_busy), 1);
        end
        chk("busy_end", 32'(ArbSt_busy), 0);
    endtask

    typedef struct {
        int          req;
        logic [3:0]  id;
        logic [3:0]  len;
        logic [27:0] addr;
        logic        ap;
        int          beats;
        int          ar_dly;
        int          nfor;
        bit          drop;
        bit          clr_first;
        bit          clr_last;
        bit          exp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [N-1:0] pend;
        int           model_last, w, nb;
        bit           err_exp, clr;

        vecs[0] = '{1, 4'd9,  4'd3,  28'h0000100, 1'b0, 4,  2, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{0, 4'd9,  4'd3,  28'h0ABCDE0, 1'b1, 4,  0, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{2, 4'd3,  4'd3,  28'h0001000, 1'b0, 2,  1, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{3, 4'd5,  4'd1,  28'hFFFFFFF, 1'b1, 2,  0, 1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{0, 4'd7,  4'd0,  28'h0000040, 1'b0, 2,  0, 0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1, 4'd2,  4'd2,  28'h1234567, 1'b1, 3,  1, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{2, 4'd15, 4'd15, 28'h0F0F0F0, 1'b0, 16, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{3, 4'd0,  4'd15, 28'h0000004, 1'b1, 17, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < N; i++) set_req(i, '0, '0, '0, 1'b0);
        ReqArb_arvalid = '0;
        BusArb_arready = 1'b0;
        BusArb_rvalid  = 1'b0;
        BusArb_rlast   = 1'b0;
        BusArb_rid     = '0;
        BusArb_rdata   = '0;
        ArbErr_clr     = 1'b0;
        rst_n          = 1'b0;
        tick();
        tick();
        chk("rst_arvalid", 32'(ArbBus_arvalid), 0);
        chk("rst_addr", 32'(ArbBus_araddr), 0);
        chk("rst_busy", 32'(ArbSt_busy), 0);
        chk("rst_grant", 32'(ArbSt_grant), 0);
        chk("rst_arready", 32'(ArbReq_arready), 0);
        chk("rst_rvalid", 32'(ArbReq_rvalid), 0);
        chk("rst_err_len", 32'(ArbErr_len), 0);
        chk("rst_err_to", 32'(ArbErr_timeout), 0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            set_req(vecs[v].req, vecs[v].id, vecs[v].len, vecs[v].addr, vecs[v].ap);
            ReqArb_arvalid = 4'b0001 << vecs[v].req;
            ArbErr_clr     = vecs[v].clr_first;
            run_burst(vecs[v].req, vecs[v].beats, vecs[v].ar_dly, vecs[v].nfor,
                      vecs[v].drop, vecs[v].clr_last);
            chk("vec_err_len", 32'(ArbErr_len), 32'(vecs[v].exp_err));
        end
        chk("err_to_default", 32'(ArbErr_timeout), 0);

        do_reset();
        set_req(0, 4'd1, 4'd0, 28'h0000010, 1'b0);
        set_req(2, 4'd2, 4'd0, 28'h0000020, 1'b1);
        set_req(3, 4'd3, 4'd0, 28'h0000030, 1'b0);
        ReqArb_arvalid = 4'b1101;
        run_burst(0, 1, 0, 0, 1'b0, 1'b0);
        ReqArb_arvalid[0] = 1'b1;
        run_burst(2, 1, 1, 0, 1'b0, 1'b0);
        run_burst(3, 1, 0, 0, 1'b0, 1'b0);
        run_burst(0, 1, 0, 0, 1'b0, 1'b0);

        do_reset();
        set_req(1, 4'd6, 4'd3, 28'h0000200, 1'b1);
        ReqArb_arvalid = 4'b0010;
        tick();
        chk("mr_grant", 32'(ArbSt_grant), 1);
        BusArb_arready = 1'b1;
        tick();
        BusArb_arready = 1'b0;
        ReqArb_arvalid = '0;
        BusArb_rvalid  = 1'b1;
        BusArb_rid     = 4'd6;
        BusArb_rdata   = 32'hCAFE0001;
        #1;
        chk("mr_beat1", 32'(ArbReq_rvalid), 32'b0010);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_arvalid", 32'(ArbBus_arvalid), 0);
        chk("mr_busy", 32'(ArbSt_busy), 0);
        chk("mr_grant0", 32'(ArbSt_grant), 0);
        chk("mr_rvalid", 32'(ArbReq_rvalid), 0);
        chk("mr_bus_id", 32'(ArbBus_aruserid), 0);
        chk("mr_bus_len", 32'(ArbBus_arlen), 0);
        tick();
        rst_n        = 1'b1;
        BusArb_rlast = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("stray_rvalid", 32'(ArbReq_rvalid), 0);
            chk("stray_busy", 32'(ArbSt_busy), 0);
            chk("stray_err", 32'(ArbErr_len), 0);
        end
        BusArb_rvalid = 1'b0;
        BusArb_rlast  = 1'b0;
        set_req(0, 4'd8, 4'd1, 28'h0000300, 1'b0);
        ReqArb_arvalid = 4'b0011;
        run_burst(0, 2, 0, 0, 1'b0, 1'b0);
        ReqArb_arvalid = '0;

`ifdef RD_TIMEOUT_EN
        do_reset();
        set_req(2, 4'd4, 4'd0, 28'h0000400, 1'b0);
        set_req(3, 4'd5, 4'd0, 28'h0000500, 1'b1);
        ReqArb_arvalid = 4'b1100;
        tick();
        chk("to_grant", 32'(ArbSt_grant), 2);
        chk("to_arvalid", 32'(ArbBus_arvalid), 1);
        for (int c = 0; c < TB_TO - 1; c++) begin
            tick();
            chk("to_hold", 32'(ArbBus_arvalid), 1);
        end
        tick();
        chk("to_drop", 32'(ArbBus_arvalid), 0);
        chk("to_flag", 32'(ArbErr_timeout), 1);
        chk("to_idle", 32'(ArbSt_busy), 0);
        ReqArb_arvalid[2] = 1'b0;
        run_burst(3, 1, 0, 0, 1'b0, 1'b0);
        chk("to_sticky", 32'(ArbErr_timeout), 1);
`endif

        do_reset();
        model_last = N - 1;
        err_exp    = 1'b0;
        pend       = '0;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, IW'($urandom), LW'($urandom_range(0, 3)), AW'($urandom),
                            1'($urandom_range(0, 1)));
                    pend[i] = 1'b1;
                end
            end
            if (pend == '0) begin
                w = $urandom_range(0, N - 1);
                set_req(w, IW'($urandom), LW'($urandom_range(0, 3)), AW'($urandom), 1'b0);
                pend[w] = 1'b1;
            end
            ReqArb_arvalid = pend;
            w  = rr_pick(model_last, pend);
            nb = int'(req_len[w]) + 1;
            if ($urandom_range(0, 4) == 0) nb = $urandom_range(1, 5);
            clr        = ($urandom_range(0, 3) == 0);
            ArbErr_clr = clr;
            run_burst(w, nb, $urandom_range(0, 2), $urandom_range(0, 2),
                      ($urandom_range(0, 3) == 0), 1'b0);
            pend[w]    = 1'b0;
            model_last = w;
            if (clr) err_exp = 1'b0;
            if (nb != int'(req_len[w]) + 1) err_exp = 1'b1;
            chk("rand_err_len", 32'(ArbErr_len), 32'(err_exp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
